// File: rtl/counter_param_if.sv
// rtl/counter_param_if.sv - control and status bundle for counter_param.
interface counter_param_if #(
   parameter int unsigned WIDTH = 64
);
   logic             en;
   logic             up;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             ovf_clr;
   logic [WIDTH-1:0] y;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, clr, load, load_val, ovf_clr,
      input  y, tc, ovf
   );

   modport slave (
      input  en, up, clr, load, load_val, ovf_clr,
      output y, tc, ovf
   );
endinterface

// File: rtl/counter_param.sv
// rtl/counter_param.sv - parametrised up/down counter with step, modulus, wrap/saturate,
// terminal-count pulse and sticky overflow flag.
module counter_param #(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
   parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
   parameter bit               SATURATE  = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   counter_param_if.slave bus
);

   // One extra bit keeps y+STEP and the modulus MAX_VAL+1 exact at WIDTH=64.
   localparam logic [WIDTH:0] MAX_X  = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] STEP_X = {1'b0, STEP};
   localparam logic [WIDTH:0] MOD_X  = MAX_X + 1'b1;

   logic [WIDTH-1:0] y_q, y_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   y_x;
   logic [WIDTH:0]   load_x;
   logic [WIDTH:0]   nxt_x;
   logic             event_w;

   always_comb begin
      y_x     = {1'b0, y_q};
      load_x  = {1'b0, bus.load_val};
      nxt_x   = y_x;
      event_w = 1'b0;

      if (bus.clr) begin
         nxt_x = '0;
      end else if (bus.load) begin
         nxt_x = (load_x > MAX_X) ? MAX_X : load_x;
      end else if (bus.en) begin
         if (bus.up) begin
            if (y_x <= MAX_X - STEP_X) begin
               nxt_x = y_x + STEP_X;
            end else begin
               event_w = 1'b1;
               nxt_x   = SATURATE ? MAX_X : (y_x + STEP_X - MOD_X);
            end
         end else begin
            if (y_x >= STEP_X) begin
               nxt_x = y_x - STEP_X;
            end else begin
               event_w = 1'b1;
               nxt_x   = SATURATE ? '0 : (y_x + MOD_X - STEP_X);
            end
         end
      end

      y_d   = nxt_x[WIDTH-1:0];
      tc_d  = event_w;
      // A new boundary event beats a same-cycle clear request.
      ovf_d = event_w | (ovf_q & ~bus.ovf_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q   <= RESET_VAL;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.y   = y_q;
   assign bus.tc  = tc_q;
   assign bus.ovf = ovf_q;

   a_y_range : assert property (@(posedge clk) disable iff (!rst_n)
      y_q <= MAX_VAL);

   a_next_range : assert property (@(posedge clk) disable iff (!rst_n)
      nxt_x <= MAX_X);

   a_tc_ovf : assert property (@(posedge clk) disable iff (!rst_n)
      tc_q |-> ovf_q);

   a_no_x : assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({y_q, tc_q, ovf_q}));

   generate
      if (STEP == WIDTH'(1) && MAX_VAL == {WIDTH{1'b1}} && !SATURATE) begin : g_free_run
         a_incr : assert property (@(posedge clk) disable iff (!rst_n)
            (bus.en && bus.up && !bus.clr && !bus.load) |=> (y_q == $past(y_q) + 1'b1));
      end
   endgenerate

endmodule

// File: tb/tb_counter_param.sv
// tb/tb_counter_param.sv - randomized and directed bench for counter_param across several configs.
module tb_counter_param;

   localparam int N = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        en, up, clr, load, ovf_clr;
   logic [63:0] lv [N];
   logic [63:0] oy [N];
   logic        otc [N];
   logic        oovf [N];

   counter_param_if #(.WIDTH(4))  b0 ();
   counter_param_if #(.WIDTH(4))  b1 ();
   counter_param_if #(.WIDTH(4))  b2 ();
   counter_param_if #(.WIDTH(64)) b3 ();
   counter_param_if #(.WIDTH(8))  b4 ();

   counter_param #(.WIDTH(4), .STEP(4'd1), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0))
      u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   counter_param #(.WIDTH(4), .STEP(4'd3), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   counter_param #(.WIDTH(4), .STEP(4'd4), .MAX_VAL(4'd9), .SATURATE(1'b1), .RESET_VAL(4'd0))
      u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   counter_param #(.WIDTH(64))
      u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   counter_param #(.WIDTH(8), .STEP(8'd7), .MAX_VAL(8'd200), .SATURATE(1'b0), .RESET_VAL(8'd5))
      u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

   assign {b0.en, b1.en, b2.en, b3.en, b4.en}                = {5{en}};
   assign {b0.up, b1.up, b2.up, b3.up, b4.up}                = {5{up}};
   assign {b0.clr, b1.clr, b2.clr, b3.clr, b4.clr}           = {5{clr}};
   assign {b0.load, b1.load, b2.load, b3.load, b4.load}      = {5{load}};
   assign {b0.ovf_clr, b1.ovf_clr, b2.ovf_clr, b3.ovf_clr, b4.ovf_clr} = {5{ovf_clr}};
   assign b0.load_val = lv[0][3:0];
   assign b1.load_val = lv[1][3:0];
   assign b2.load_val = lv[2][3:0];
   assign b3.load_val = lv[3];
   assign b4.load_val = lv[4][7:0];

   assign oy[0] = {60'd0, b0.y};
   assign oy[1] = {60'd0, b1.y};
   assign oy[2] = {60'd0, b2.y};
   assign oy[3] = b3.y;
   assign oy[4] = {56'd0, b4.y};
   assign otc[0] = b0.tc;  assign oovf[0] = b0.ovf;
   assign otc[1] = b1.tc;  assign oovf[1] = b1.ovf;
   assign otc[2] = b2.tc;  assign oovf[2] = b2.ovf;
   assign otc[3] = b3.tc;  assign oovf[3] = b3.ovf;
   assign otc[4] = b4.tc;  assign oovf[4] = b4.ovf;

   // Per-instance configuration and reference state, 66 bits so MAX_VAL+STEP never overflows.
   logic [65:0] c_max [N];
   logic [65:0] c_step [N];
   logic [65:0] c_rst [N];
   logic [65:0] c_mask [N];
   bit          c_sat [N];
   logic [65:0] my [N];
   bit          mtc [N];
   bit          movf [N];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         my[i]   = c_rst[i];
         mtc[i]  = 1'b0;
         movf[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         logic [65:0] lvm, s, m;
         bit ev;
         ev  = 1'b0;
         m   = c_max[i] + 66'd1;
         lvm = {2'b00, lv[i]} & c_mask[i];
         if (clr) begin
            my[i] = '0;
         end else if (load) begin
            my[i] = (lvm > c_max[i]) ? c_max[i] : lvm;
         end else if (en) begin
            if (up) begin
               s  = my[i] + c_step[i];
               ev = (s > c_max[i]);
               my[i] = !ev ? s : (c_sat[i] ? c_max[i] : s % m);
            end else begin
               ev = (my[i] < c_step[i]);
               my[i] = !ev ? my[i] - c_step[i]
                           : (c_sat[i] ? 66'd0 : (my[i] + m - c_step[i]) % m);
            end
         end
         mtc[i]  = ev;
         movf[i] = ev | (movf[i] & !ovf_clr);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N; i++) begin
         check_eq($sformatf("%s_y%0d", tag, i), {2'b00, oy[i]}, my[i]);
         check_eq($sformatf("%s_tc%0d", tag, i), {65'd0, otc[i]}, {65'd0, mtc[i]});
         check_eq($sformatf("%s_ovf%0d", tag, i), {65'd0, oovf[i]}, {65'd0, movf[i]});
      end
   endtask

   task automatic set_in(input logic e, input logic u, input logic c, input logic l, input logic oc);
      en = e; up = u; clr = c; load = l; ovf_clr = oc;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Called one time unit after an edge: reset lands between edges and must act at once.
   task automatic async_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1;
      check_all("rst_held");
      rst_n = 1'b1;
   endtask

   int exp_c [4]  = '{8, 5, 2, 9};
   int exp_ct [4] = '{1, 0, 0, 1};
   int exp_d [5]  = '{9, 9, 5, 1, 0};
   int exp_dt [5] = '{1, 1, 0, 0, 1};

   initial begin
      c_max[0] = 9;   c_step[0] = 1; c_sat[0] = 0; c_rst[0] = 0; c_mask[0] = 66'hF;
      c_max[1] = 9;   c_step[1] = 3; c_sat[1] = 0; c_rst[1] = 0; c_mask[1] = 66'hF;
      c_max[2] = 9;   c_step[2] = 4; c_sat[2] = 1; c_rst[2] = 0; c_mask[2] = 66'hF;
      c_max[3] = 66'hFFFF_FFFF_FFFF_FFFF; c_step[3] = 1; c_sat[3] = 0; c_rst[3] = 0;
      c_mask[3] = 66'hFFFF_FFFF_FFFF_FFFF;
      c_max[4] = 200; c_step[4] = 7; c_sat[4] = 0; c_rst[4] = 5; c_mask[4] = 66'hFF;
      for (int i = 0; i < N; i++) lv[i] = '0;
      set_in(0, 1, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all("reset");
      check_eq("rstval_u4", {2'b00, oy[4]}, 66'd5);
      rst_n = 1'b1;

      // Reset mid-count, then first edge after release counts.
      for (int i = 0; i < N; i++) lv[i] = 64'd5;
      set_in(0, 1, 0, 1, 0);
      tick("load5");
      check_eq("load5_u0", {2'b00, oy[0]}, 66'd5);
      async_reset();
      check_eq("rst_mid_u0", {2'b00, oy[0]}, 66'd0);
      set_in(1, 1, 0, 0, 0);
      tick("post_rst");
      check_eq("post_rst_u0", {2'b00, oy[0]}, 66'd1);

      // Up wrap on u0.
      lv[0] = 64'd8;
      set_in(0, 1, 0, 1, 0);
      tick("upwrap_ld");
      set_in(1, 1, 0, 0, 0);
      tick("upwrap");
      check_eq("upwrap_9", {2'b00, oy[0]}, 66'd9);
      check_eq("upwrap_tc9", {65'd0, otc[0]}, 66'd0);
      tick("upwrap");
      check_eq("upwrap_0", {2'b00, oy[0]}, 66'd0);
      check_eq("upwrap_tc0", {65'd0, otc[0]}, 66'd1);
      tick("upwrap");
      check_eq("upwrap_1", {2'b00, oy[0]}, 66'd1);
      check_eq("upwrap_ovf", {65'd0, oovf[0]}, 66'd1);
      set_in(0, 1, 0, 0, 1);
      tick("ovfclr");
      check_eq("ovfclr_u0", {65'd0, oovf[0]}, 66'd0);

      // Down wrap with STEP=3 on u1.
      lv[1] = 64'd1;
      set_in(0, 0, 0, 1, 0);
      tick("dn_ld");
      set_in(1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick("dnwrap");
         check_eq("dnwrap_y", {2'b00, oy[1]}, 66'(exp_c[k]));
         check_eq("dnwrap_tc", {65'd0, otc[1]}, 66'(exp_ct[k]));
      end

      // Saturate with STEP=4 on u2.
      lv[2] = 64'd7;
      set_in(0, 1, 0, 1, 0);
      tick("sat_ld");
      for (int k = 0; k < 5; k++) begin
         set_in(1, (k < 2), 0, 0, 0);
         tick("sat");
         check_eq("sat_y", {2'b00, oy[2]}, 66'(exp_d[k]));
         check_eq("sat_tc", {65'd0, otc[2]}, 66'(exp_dt[k]));
      end

      // Priority, load clamp, event beating ovf_clr on u0.
      set_in(1, 1, 1, 1, 0);
      tick("prio");
      check_eq("prio_clr", {2'b00, oy[0]}, 66'd0);
      lv[0] = 64'd14;
      set_in(1, 1, 0, 1, 0);
      tick("clamp");
      check_eq("clamp_y", {2'b00, oy[0]}, 66'd9);
      check_eq("clamp_tc", {65'd0, otc[0]}, 66'd0);
      set_in(0, 1, 0, 0, 1);
      tick("ovf_pre");
      set_in(1, 1, 0, 0, 1);
      tick("ovf_race");
      check_eq("ovf_race_u0", {65'd0, oovf[0]}, 66'd1);

      // 64-bit full-modulus wrap on u3.
      lv[3] = 64'hFFFF_FFFF_FFFF_FFFE;
      set_in(0, 1, 0, 1, 0);
      tick("w64_ld");
      set_in(1, 1, 0, 0, 0);
      tick("w64");
      check_eq("w64_max", {2'b00, oy[3]}, 66'hFFFF_FFFF_FFFF_FFFF);
      tick("w64");
      check_eq("w64_zero", {2'b00, oy[3]}, 66'd0);
      check_eq("w64_tc", {65'd0, otc[3]}, 66'd1);
      tick("w64");
      check_eq("w64_one", {2'b00, oy[3]}, 66'd1);

      // Randomized traffic, with loads biased toward boundaries and occasional reset.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) lv[i] = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) lv[3] = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 12));
         set_in(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 63) == 0) async_reset();
         else tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
